// File: rtl/mul8_mac_pkg.sv
// Shared constants, stage payload type and the overflow-aware accumulate helper
// for the mul8 multiply-accumulate pipeline.
package mul8_mac_pkg;

  localparam int unsigned OPW       = 8;
  localparam int unsigned PROD_W    = 16;
  localparam int unsigned MAX_ACC_W = 32;

  // Control payload travelling alongside the operand and product stages.
  typedef struct packed {
    logic valid;
    logic last;
  } stage_t;

  typedef struct packed {
    logic                 ovf;
    logic [MAX_ACC_W-1:0] sum;
  } add_res_t;

  // Adds a product to an acc_w-bit accumulator; the result is clamped to all-ones
  // or wrapped modulo 2^acc_w when the carry out of bit acc_w-1 is set.
  function automatic add_res_t mac_add(input logic [MAX_ACC_W-1:0] acc,
                                       input logic [PROD_W-1:0]    prod,
                                       input int unsigned          acc_w,
                                       input logic                 saturate);
    logic [MAX_ACC_W:0] full;
    logic [MAX_ACC_W:0] mask;
    add_res_t           res;
    mask     = (33'd1 << acc_w) - 33'd1;
    full     = {1'b0, acc} + 33'(prod);
    res.ovf  = |(full & ~mask);
    res.sum  = full[MAX_ACC_W-1:0] & mask[MAX_ACC_W-1:0];
    if (res.ovf && saturate) begin
      res.sum = mask[MAX_ACC_W-1:0];
    end
    return res;
  endfunction

endpackage

// File: rtl/mul8_mac_acc.sv
// Accumulate stage: per-packet running sum, saturating beat counter, sticky
// overflow and the valid/ready result register that also sources the stall.
module mul8_mac_acc
  import mul8_mac_pkg::*;
#(
  parameter int unsigned ACC_W    = 24,
  parameter int unsigned CNT_W    = 8,
  parameter bit          SATURATE = 1'b1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  stage_t            st2_i,
  input  logic [PROD_W-1:0] prod_i,
  input  logic              m_ready_i,
  output logic              stall_o,
  output logic              m_valid_o,
  output logic [ACC_W-1:0]  m_sum_o,
  output logic [CNT_W-1:0]  m_count_o,
  output logic              m_ovf_o
);

  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             m_valid_q, m_valid_d;
  logic [ACC_W-1:0] m_sum_q, m_sum_d;
  logic [CNT_W-1:0] m_count_q, m_count_d;
  logic             m_ovf_q, m_ovf_d;

  add_res_t         add_res;
  logic [ACC_W-1:0] sum_next;
  logic [CNT_W-1:0] cnt_inc;
  logic             stall;
  logic             unused_sum_hi;

  assign stall         = m_valid_q && !m_ready_i;
  assign add_res       = mac_add(MAX_ACC_W'(acc_q), prod_i, ACC_W, SATURATE);
  assign sum_next      = add_res.sum[ACC_W-1:0];
  assign unused_sum_hi = ^(add_res.sum >> ACC_W);
  assign cnt_inc       = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);

  always_comb begin
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    ovf_d     = ovf_q;
    m_valid_d = m_valid_q;
    m_sum_d   = m_sum_q;
    m_count_d = m_count_q;
    m_ovf_d   = m_ovf_q;
    if (!stall) begin
      if (m_valid_q && m_ready_i) begin
        m_valid_d = 1'b0;
      end
      if (st2_i.valid) begin
        if (st2_i.last) begin
          // A completing packet overrides the handshake clear, so no bubble appears.
          m_valid_d = 1'b1;
          m_sum_d   = sum_next;
          m_count_d = cnt_inc;
          m_ovf_d   = ovf_q | add_res.ovf;
          acc_d     = '0;
          cnt_d     = '0;
          ovf_d     = 1'b0;
        end else begin
          acc_d = sum_next;
          cnt_d = cnt_inc;
          ovf_d = ovf_q | add_res.ovf;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      acc_q     <= '0;
      cnt_q     <= '0;
      ovf_q     <= 1'b0;
      m_valid_q <= 1'b0;
      m_sum_q   <= '0;
      m_count_q <= '0;
      m_ovf_q   <= 1'b0;
    end else begin
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      ovf_q     <= ovf_d;
      m_valid_q <= m_valid_d;
      m_sum_q   <= m_sum_d;
      m_count_q <= m_count_d;
      m_ovf_q   <= m_ovf_d;
    end
  end

  assign stall_o   = stall;
  assign m_valid_o = m_valid_q;
  assign m_sum_o   = m_sum_q;
  assign m_count_o = m_count_q;
  assign m_ovf_o   = m_ovf_q;

endmodule

// File: rtl/mul8_mac_pipe.sv
// Three-stage multiply-accumulate around an external 8x8 multiplier: registered
// operands, registered product, then per-packet accumulation with a valid/ready result.
module mul8_mac_pipe
  import mul8_mac_pkg::*;
#(
  parameter int unsigned ACC_W      = 24,
  parameter int unsigned CNT_W      = 8,
  parameter bit          SATURATE   = 1'b1,
  parameter bit          ZERO_GUARD = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [OPW-1:0]    s_a,
  input  logic [OPW-1:0]    s_b,
  input  logic              s_last,
  output logic [OPW-1:0]    mul_a,
  output logic [OPW-1:0]    mul_b,
  input  logic [PROD_W-1:0] mul_o,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [ACC_W-1:0]  m_sum,
  output logic [CNT_W-1:0]  m_count,
  output logic              m_ovf
);

  logic [OPW-1:0]    mul_a_q, mul_a_d;
  logic [OPW-1:0]    mul_b_q, mul_b_d;
  stage_t            st1_q, st1_d;
  stage_t            st2_q, st2_d;
  logic [PROD_W-1:0] prod_q, prod_d;

  logic stall;
  logic accept;
  logic zero_hit;

  assign s_ready  = rst_n && !stall;
  assign accept   = s_valid && s_ready;
  // Approximate multipliers may return nonzero for a zero operand; optionally mask it.
  assign zero_hit = ZERO_GUARD && ((mul_a_q == '0) || (mul_b_q == '0));

  always_comb begin
    mul_a_d = mul_a_q;
    mul_b_d = mul_b_q;
    st1_d   = st1_q;
    st2_d   = st2_q;
    prod_d  = prod_q;
    if (!stall) begin
      if (accept) begin
        mul_a_d    = s_a;
        mul_b_d    = s_b;
        st1_d.valid = 1'b1;
        st1_d.last  = s_last;
      end else begin
        st1_d = '0;
      end
      st2_d  = st1_q;
      prod_d = zero_hit ? '0 : mul_o;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mul_a_q <= '0;
      mul_b_q <= '0;
      st1_q   <= '0;
      st2_q   <= '0;
      prod_q  <= '0;
    end else begin
      mul_a_q <= mul_a_d;
      mul_b_q <= mul_b_d;
      st1_q   <= st1_d;
      st2_q   <= st2_d;
      prod_q  <= prod_d;
    end
  end

  assign mul_a = mul_a_q;
  assign mul_b = mul_b_q;

  mul8_mac_acc #(
    .ACC_W   (ACC_W),
    .CNT_W   (CNT_W),
    .SATURATE(SATURATE)
  ) u_acc (
    .clk_i    (clk),
    .rst_ni   (rst_n),
    .st2_i    (st2_q),
    .prod_i   (prod_q),
    .m_ready_i(m_ready),
    .stall_o  (stall),
    .m_valid_o(m_valid),
    .m_sum_o  (m_sum),
    .m_count_o(m_count),
    .m_ovf_o  (m_ovf)
  );

endmodule

// File: tb/tb_mul8_mac_pipe.sv
// Bench for mul8_mac_pipe: five parameter variants share one stimulus stream and are
// scored against a per-packet arithmetic reference model.
module tb_mul8_mac_pipe;

  localparam int NI = 5;
  localparam int unsigned ACCW [NI] = '{24, 24, 16, 16, 24};
  localparam int unsigned CNTW [NI] = '{8, 8, 8, 8, 2};
  localparam bit          SAT  [NI] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
  localparam bit          ZG   [NI] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};

  logic        clk = 1'b0;
  logic        rst_n, s_valid, s_last, m_ready, force_en;
  logic [7:0]  s_a, s_b;
  logic [15:0] force_val;

  logic        s_ready_w [NI];
  logic        m_valid_w [NI];
  logic        m_ovf_w   [NI];
  logic [7:0]  mul_a_w   [NI];
  logic [7:0]  mul_b_w   [NI];
  logic [31:0] sum_w     [NI];
  logic [31:0] cnt_w     [NI];

  int n_cmp = 0;
  int n_err = 0;
  bit rnd_done;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int unsigned AW = ACCW[g];
    localparam int unsigned CW = CNTW[g];
    logic [AW-1:0] m_sum;
    logic [CW-1:0] m_count;
    logic [15:0]   mul_o;
    logic [7:0]    mul_a, mul_b;
    logic          s_ready, m_valid, m_ovf;

    assign mul_o = force_en ? force_val : 16'(mul_a) * 16'(mul_b);

    mul8_mac_pipe #(
      .ACC_W     (AW),
      .CNT_W     (CW),
      .SATURATE  (SAT[g]),
      .ZERO_GUARD(ZG[g])
    ) u_dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .s_valid(s_valid),
      .s_ready(s_ready),
      .s_a    (s_a),
      .s_b    (s_b),
      .s_last (s_last),
      .mul_a  (mul_a),
      .mul_b  (mul_b),
      .mul_o  (mul_o),
      .m_valid(m_valid),
      .m_ready(m_ready),
      .m_sum  (m_sum),
      .m_count(m_count),
      .m_ovf  (m_ovf)
    );

    assign s_ready_w[g] = s_ready;
    assign m_valid_w[g] = m_valid;
    assign m_ovf_w[g]   = m_ovf;
    assign mul_a_w[g]   = mul_a;
    assign mul_b_w[g]   = mul_b;
    assign sum_w[g]     = 32'(m_sum);
    assign cnt_w[g]     = 32'(m_count);
  end

  task automatic check_eq(input string tag, input longint obs, input longint expv);
    n_cmp++;
    if (obs != expv) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, expv);
    end
  endtask

  // Reference model: accepted beats of the open packet; results queued per completed packet.
  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    bit          fen;
    logic [15:0] fval;
  } beat_t;

  typedef struct {
    longint sum [NI];
    longint cnt [NI];
    longint ovf [NI];
  } exp_t;

  beat_t beats[$];
  exp_t  exp_q[$];

  function automatic exp_t model_packet();
    exp_t r;
    for (int i = 0; i < NI; i++) begin
      longint acc = 0;
      longint lim = longint'(1) << ACCW[i];
      longint cmax = (longint'(1) << CNTW[i]) - 1;
      longint ovf = 0;
      foreach (beats[j]) begin
        longint p;
        if (ZG[i] && (beats[j].a == 0 || beats[j].b == 0)) p = 0;
        else if (beats[j].fen) p = longint'(beats[j].fval);
        else p = longint'(beats[j].a) * longint'(beats[j].b);
        acc += p;
        if (acc >= lim) begin
          ovf = 1;
          acc = SAT[i] ? lim - 1 : acc - lim;
        end
      end
      r.sum[i] = acc;
      r.ovf[i] = ovf;
      r.cnt[i] = (beats.size() > cmax) ? cmax : longint'(beats.size());
    end
    return r;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    beat_t bt;
    if (!rst_n) begin
      beats.delete();
      exp_q.delete();
    end else begin
      if (m_valid_w[0] && m_ready) begin
        if (exp_q.size() == 0) begin
          check_eq("spurious_output", 1, 0);
        end else begin
          e = exp_q.pop_front();
          for (int i = 0; i < NI; i++) begin
            check_eq($sformatf("sb_sum[%0d]", i), sum_w[i], e.sum[i]);
            check_eq($sformatf("sb_count[%0d]", i), cnt_w[i], e.cnt[i]);
            check_eq($sformatf("sb_ovf[%0d]", i), m_ovf_w[i], e.ovf[i]);
            check_eq($sformatf("sb_valid[%0d]", i), m_valid_w[i], 1);
            check_eq($sformatf("sb_s_ready[%0d]", i), s_ready_w[i], 1);
          end
        end
      end
      if (s_valid && s_ready_w[0]) begin
        bt.a = s_a; bt.b = s_b; bt.fen = force_en; bt.fval = force_val;
        beats.push_back(bt);
        if (s_last) begin
          exp_q.push_back(model_packet());
          beats.delete();
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [7:0] a, input logic [7:0] b, input logic last);
    int w = 0;
    s_valid = 1'b1; s_a = a; s_b = b; s_last = last;
    @(negedge clk);
    while (!s_ready_w[0] && w < 500) begin
      @(negedge clk);
      w++;
    end
    if (w >= 500) check_eq("accept_timeout", 0, 1);
    @(posedge clk);
    #1;
    s_valid = 1'b0; s_last = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; s_valid = 1'b0; s_last = 1'b0; s_a = '0; s_b = '0;
    m_ready = 1'b1; force_en = 1'b0; force_val = '0; rnd_done = 1'b0;
    step(); step();
    check_eq("rst_m_valid", m_valid_w[0], 0);
    check_eq("rst_m_sum", sum_w[0], 0);
    check_eq("rst_m_count", cnt_w[0], 0);
    check_eq("rst_m_ovf", m_ovf_w[0], 0);
    check_eq("rst_mul_a", mul_a_w[0], 0);
    check_eq("rst_s_ready", s_ready_w[0], 0);
    rst_n = 1'b1;
    #1;
    check_eq("post_rst_s_ready", s_ready_w[0], 1);

    // Basic dot product and latency
    beat(8'd3, 8'd5, 1'b0);
    beat(8'd10, 8'd10, 1'b0);
    beat(8'd255, 8'd255, 1'b0);
    beat(8'd0, 8'd7, 1'b1);
    check_eq("lat_edge_k", m_valid_w[0], 0);
    step();
    check_eq("lat_edge_k1", m_valid_w[0], 0);
    step();
    check_eq("lat_edge_k2", m_valid_w[0], 1);
    check_eq("t1_sum", sum_w[0], 65140);
    check_eq("t1_count", cnt_w[0], 4);
    check_eq("t1_ovf", m_ovf_w[0], 0);
    step();

    // Zero guard against a forced nonzero product
    force_en = 1'b1; force_val = 16'h0063;
    beat(8'd0, 8'd200, 1'b1);
    step(); step();
    check_eq("zg_on_sum", sum_w[0], 0);
    check_eq("zg_off_sum", sum_w[1], 99);
    step(); step();
    force_en = 1'b0;

    // 16-bit accumulator overflow
    beat(8'd255, 8'd255, 1'b0);
    beat(8'd255, 8'd255, 1'b1);
    step(); step();
    check_eq("sat_sum", sum_w[2], 65535);
    check_eq("sat_ovf", m_ovf_w[2], 1);
    check_eq("wrap_sum", sum_w[3], 64514);
    check_eq("wrap_ovf", m_ovf_w[3], 1);
    check_eq("wide_sum", sum_w[0], 130050);
    check_eq("wide_ovf", m_ovf_w[0], 0);
    step();

    // Back-pressure: held result, stable operands, bubble-free reload
    m_ready = 1'b0;
    beat(8'd2, 8'd3, 1'b1);
    beat(8'd4, 8'd5, 1'b1);
    step();
    check_eq("stall_valid", m_valid_w[0], 1);
    check_eq("stall_sum", sum_w[0], 6);
    check_eq("stall_s_ready", s_ready_w[0], 0);
    repeat (3) step();
    check_eq("stall_hold_sum", sum_w[0], 6);
    for (int i = 0; i < NI; i++) begin
      check_eq($sformatf("stall_mul_a[%0d]", i), mul_a_w[i], 4);
      check_eq($sformatf("stall_mul_b[%0d]", i), mul_b_w[i], 5);
    end
    m_ready = 1'b1;
    step();
    m_ready = 1'b0;
    check_eq("reload_valid", m_valid_w[0], 1);
    check_eq("reload_sum", sum_w[0], 20);
    check_eq("reload_count", cnt_w[0], 1);
    step();
    check_eq("reload_hold_valid", m_valid_w[0], 1);
    m_ready = 1'b1;
    step(); step();
    check_eq("drained_valid", m_valid_w[0], 0);

    // Mid-packet reset discards the partial packet
    beat(8'd1, 8'd1, 1'b0);
    beat(8'd1, 8'd1, 1'b0);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    beat(8'd7, 8'd7, 1'b1);
    step(); step();
    check_eq("rst_pkt_sum", sum_w[0], 49);
    check_eq("rst_pkt_count", cnt_w[0], 1);
    step();

    // Counter saturation with bubbles
    beat(8'd1, 8'd1, 1'b0);
    beat(8'd1, 8'd1, 1'b0);
    step(); step();
    beat(8'd1, 8'd1, 1'b0);
    beat(8'd1, 8'd1, 1'b0);
    beat(8'd1, 8'd1, 1'b1);
    step(); step();
    check_eq("cnt2_sum", sum_w[4], 5);
    check_eq("cnt2_count", cnt_w[4], 3);
    check_eq("cnt8_count", cnt_w[0], 5);
    step();

    // Randomized packets with random back-pressure and bubbles
    fork
      begin
        for (int p = 0; p < 150; p++) begin
          int len = int'($urandom_range(1, 6));
          for (int j = 0; j < len; j++) begin
            logic [7:0] a, b;
            a = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(0, 255));
            b = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(0, 255));
            beat(a, b, (j == len - 1));
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 2)) step();
          end
        end
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          step();
          m_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    m_ready = 1'b1;
    repeat (8) step();
    check_eq("drain_exp_empty", exp_q.size(), 0);
    check_eq("drain_open_beats", beats.size(), 0);
    check_eq("drain_valid", m_valid_w[0], 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
